// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Multi-cycle shift-and-add multiplier with configurable operand width, bits
// retired per cycle, and per-operation signed/unsigned mode. Signed operands
// are reduced to magnitudes on acceptance. The magnitude product is then
// accumulated STEP multiplier bits at a time. The final sum is negated on
// completion when exactly one operand was negative.
//
// Parameters:
//   WIDTH  operand width (>= 2); result is 2*WIDTH bits
//   STEP   multiplier bits retired per cycle; WIDTH must be a multiple of STEP
//
// Ports:
//   clk_i     in   1         clock, rising edge
//   rst_ni    in   1         asynchronous active-low reset
//   start_i   in   1         operation request, sampled in IDLE or DONE
//   signed_i  in   1         1 = two's-complement operands, sampled with start_i
//   a_i       in   WIDTH     multiplicand, sampled with start_i
//   b_i       in   WIDTH     multiplier, sampled with start_i
//   busy_o    out  1         operation in progress
//   finish_o  out  1         one-cycle completion pulse
//   result_o  out  2*WIDTH   product, held until the next completion or reset
//
// Build option:
//   SEQ_MULT_EARLY_TERM_EN  when defined, RUN ends as soon as the remaining
//                           multiplier bits are all zero. Results are
//                           unchanged; only latency shrinks.
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 finish_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reject unusable parameter sets at elaboration time.
  if (WIDTH < 2) begin : g_bad_width
    $error("seq_multiplier: WIDTH must be >= 2");
  end
  if ((WIDTH % STEP) != 0) begin : g_bad_step
    $error("seq_multiplier: WIDTH must be a multiple of STEP");
  end

  logic [1:0]          state_q,  state_d;
  logic [2*WIDTH-1:0]  mag_a_q,  mag_a_d;   // multiplicand, pre-shifted to the current bit position
  logic [WIDTH-1:0]    mag_b_q,  mag_b_d;   // remaining multiplier bits
  logic [2*WIDTH-1:0]  acc_q,    acc_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                neg_q,    neg_d;
  logic                busy_q,   busy_d;
  logic                finish_q, finish_d;
  logic [2*WIDTH-1:0]  result_q, result_d;

  logic                accept_s;
  logic [WIDTH-1:0]    a_mag_s;
  logic [WIDTH-1:0]    b_mag_s;
  logic [2*WIDTH-1:0]  b_bits_s;
  logic [2*WIDTH-1:0]  acc_sum_s;
  logic [WIDTH-1:0]    rem_b_s;
  logic                last_s;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d  = state_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;

    accept_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // The magnitude of the most negative value wraps to itself, which is
    // exactly right when read as an unsigned WIDTH-bit number.
    if (signed_i && a_i[WIDTH-1]) begin
      a_mag_s = {WIDTH{1'b0}} - a_i;
    end else begin
      a_mag_s = a_i;
    end
    if (signed_i && b_i[WIDTH-1]) begin
      b_mag_s = {WIDTH{1'b0}} - b_i;
    end else begin
      b_mag_s = b_i;
    end

    b_bits_s  = {{(2*WIDTH-STEP){1'b0}}, mag_b_q[STEP-1:0]};
    acc_sum_s = acc_q + (mag_a_q * b_bits_s);
    rem_b_s   = mag_b_q >> STEP;

`ifdef SEQ_MULT_EARLY_TERM_EN
    last_s = (cnt_q == CNT_W'(1)) || (rem_b_s == {WIDTH{1'b0}});
`else
    last_s = (cnt_q == CNT_W'(1));
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          mag_a_d = {{WIDTH{1'b0}}, a_mag_s};
          mag_b_d = b_mag_s;
          neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          acc_d   = {(2*WIDTH){1'b0}};
          cnt_d   = CNT_W'(N);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_sum_s;
        mag_a_d = mag_a_q << STEP;
        mag_b_d = rem_b_s;
        cnt_d   = cnt_q - CNT_W'(1);
        if (last_s) begin
          state_d = ST_DONE;
          // Negating a zero sum gives zero, so no special case is needed.
          if (neg_q) begin
            result_d = {(2*WIDTH){1'b0}} - acc_sum_s;
          end else begin
            result_d = acc_sum_s;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the next state so they align with it.
    busy_d   = (state_d == ST_RUN);
    finish_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      mag_a_q  <= {(2*WIDTH){1'b0}};
      mag_b_q  <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign finish_o = finish_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed self-checking bench for seq_multiplier. It drives a default
// 32x32 STEP=1 instance and a WIDTH=16 STEP=4 instance. Latency expectations
// follow SEQ_MULT_EARLY_TERM_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        finish;
  logic [63:0] result;

  logic        start16;
  logic        sgn16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        finish16;
  logic [31:0] result16;

  int checks;
  int errors;

  seq_multiplier #(.WIDTH(32), .STEP(1)) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .signed_i (sgn),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .finish_o (finish),
    .result_o (result)
  );

  seq_multiplier #(.WIDTH(16), .STEP(4)) u_dut16 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start16),
    .signed_i (sgn16),
    .a_i      (a16),
    .b_i      (b16),
    .busy_o   (busy16),
    .finish_o (finish16),
    .result_o (result16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation on the 32-bit unit and measure it (no comparisons here).
  task automatic do_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       output logic [63:0] res, output int lat, output logic busy_e0,
                       output logic busy_fin, output logic fin_after);
    @(negedge clk);
    start = 1'b1; sgn = s; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h0; b = 32'h0; sgn = 1'b0;
    busy_e0  = busy;
    busy_fin = 1'b1;
    res      = 64'h0;
    lat      = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (finish) begin
        busy_fin = busy;
        res      = result;
        break;
      end
    end
    @(posedge clk); #1;
    fin_after = finish;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = 32'h0; b = 32'h0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    #2;
    checks++;
    if ({busy, finish, result} !== {1'b0, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL reset_state: busy=%b finish=%b result=%0h, expected 0 0 0", busy, finish, result);
    end
    checks++;
    if ({busy16, finish16, result16} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state16: busy=%b finish=%b result=%0h, expected 0 0 0", busy16, finish16, result16);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max();
    logic [63:0] res; int lat; logic be0, bf, fa;
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'd18446744065119617025) begin
      errors++; $display("FAIL umax_result: got %0d expected 18446744065119617025", res);
    end
    checks++;
    if (lat !== 32) begin
      errors++; $display("FAIL umax_latency: got %0d expected 32", lat);
    end
    checks++;
    if (be0 !== 1'b1) begin
      errors++; $display("FAIL umax_busy_e0: got %b expected 1", be0);
    end
    checks++;
    if (bf !== 1'b0) begin
      errors++; $display("FAIL umax_busy_at_finish: got %b expected 0", bf);
    end
    checks++;
    if (fa !== 1'b0) begin
      errors++; $display("FAIL umax_finish_width: got %b expected 0", fa);
    end
  endtask

  task automatic test_signed();
    logic [63:0] res; int lat; logic be0, bf, fa;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd6, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      errors++; $display("FAIL s_m7x6: got %0h expected ffffffffffffffd6", res);
    end
    checks++;
    if (lat !== (ET ? 3 : 32)) begin
      errors++; $display("FAIL s_m7x6_latency: got %0d expected %0d", lat, (ET ? 3 : 32));
    end
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL s_minxmin: got %0h expected 4000000000000000", res);
    end
    checks++;
    if (lat !== 32) begin
      errors++; $display("FAIL s_minxmin_latency: got %0d expected 32", lat);
    end
    do_op(1'b1, 32'h0, 32'hFFFF_FFFB, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'h0) begin
      errors++; $display("FAIL s_0xm5: got %0h expected 0", res);
    end
  endtask

  task automatic test_back_to_back();
    int t; int nfin; int fin_t[3]; logic [63:0] fin_r[3]; logic fin_busy[3];
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    t = 0; nfin = 0;
    for (int i = 0; i < 300 && nfin < 3; i++) begin
      @(posedge clk); #1;
      t++;
      // Operands for op 2 appear mid-way through op 1 and must not disturb it.
      if (t == 2) begin
        a = 32'd7; b = 32'd0;
      end
      if (finish) begin
        fin_r[nfin] = result; fin_t[nfin] = t; fin_busy[nfin] = busy;
        nfin++;
        if (nfin == 2) begin
          a = 32'd1; b = 32'd1;
        end
        if (nfin == 3) begin
          start = 1'b0;
        end
      end else if (nfin == 2 && t == fin_t[1] + 3) begin
        a = 32'd9; b = 32'd9;
      end
    end
    start = 1'b0;
    checks++;
    if (nfin !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d completions expected 3", nfin);
    end else begin
      checks++;
      if (fin_r[0] !== 64'd15) begin
        errors++; $display("FAIL b2b_res0: got %0d expected 15", fin_r[0]);
      end
      checks++;
      if (fin_r[1] !== 64'd0) begin
        errors++; $display("FAIL b2b_res1: got %0d expected 0", fin_r[1]);
      end
      checks++;
      if (fin_r[2] !== 64'd1) begin
        errors++; $display("FAIL b2b_res2: got %0d expected 1", fin_r[2]);
      end
      checks++;
      if ((fin_t[1] - fin_t[0]) !== (ET ? 2 : 33)) begin
        errors++; $display("FAIL b2b_spacing01: got %0d expected %0d", fin_t[1] - fin_t[0], (ET ? 2 : 33));
      end
      checks++;
      if ((fin_t[2] - fin_t[1]) !== (ET ? 2 : 33)) begin
        errors++; $display("FAIL b2b_spacing12: got %0d expected %0d", fin_t[2] - fin_t[1], (ET ? 2 : 33));
      end
      checks++;
      if ({fin_busy[0], fin_busy[1], fin_busy[2]} !== 3'b000) begin
        errors++; $display("FAIL b2b_busy_at_finish: got %b%b%b expected 000", fin_busy[0], fin_busy[1], fin_busy[2]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, finish} !== 2'b00) begin
      errors++; $display("FAIL b2b_stop: busy=%b finish=%b expected 0 0", busy, finish);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (result !== 64'd1) begin
      errors++; $display("FAIL result_hold_idle: got %0d expected 1", result);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] res; int lat; logic be0, bf, fa; int seen;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, finish, result} !== {1'b0, 1'b0, 64'h0}) begin
      errors++; $display("FAIL reset_async: busy=%b finish=%b result=%0h expected 0 0 0", busy, finish, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (finish) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_no_finish: got %0d finish pulses expected 0", seen);
    end
    do_op(1'b0, 32'd2, 32'd2, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'd4) begin
      errors++; $display("FAIL after_reset_2x2: got %0d expected 4", res);
    end
    checks++;
    if (lat !== (ET ? 2 : 32)) begin
      errors++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, (ET ? 2 : 32));
    end
  endtask

  task automatic test_width16_step4();
    logic [31:0] vec_a[2]; logic [31:0] vec_b[2]; logic vec_s[2];
    logic [31:0] exp_r[2]; int exp_l[2]; int lat; logic [31:0] res;
    vec_a[0] = 32'h0000_FFFF; vec_b[0] = 32'h0000_FFFF; vec_s[0] = 1'b0;
    exp_r[0] = 32'd4294836225; exp_l[0] = 4;
    vec_a[1] = 32'h0000_FFFF; vec_b[1] = 32'h0000_FFFF; vec_s[1] = 1'b1;
    exp_r[1] = 32'd1; exp_l[1] = ET ? 1 : 4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start16 = 1'b1; sgn16 = vec_s[k]; a16 = vec_a[k][15:0]; b16 = vec_b[k][15:0];
      @(posedge clk); #1;
      start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
      lat = 0; res = 32'h0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #1;
        lat++;
        if (finish16) begin
          res = result16;
          break;
        end
      end
      checks++;
      if (res !== exp_r[k]) begin
        errors++; $display("FAIL w16_result%0d: got %0d expected %0d", k, res, exp_r[k]);
      end
      checks++;
      if (lat !== exp_l[k]) begin
        errors++; $display("FAIL w16_latency%0d: got %0d expected %0d", k, lat, exp_l[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_term();
    logic [63:0] res; int lat; logic be0, bf, fa;
    do_op(1'b0, 32'd123, 32'd0, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'd0) begin
      errors++; $display("FAIL et_b0_result: got %0d expected 0", res);
    end
    checks++;
    if (lat !== (ET ? 1 : 32)) begin
      errors++; $display("FAIL et_b0_latency: got %0d expected %0d", lat, (ET ? 1 : 32));
    end
    do_op(1'b0, 32'd1000, 32'd5, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'd5000) begin
      errors++; $display("FAIL et_b5_result: got %0d expected 5000", res);
    end
    checks++;
    if (lat !== (ET ? 3 : 32)) begin
      errors++; $display("FAIL et_b5_latency: got %0d expected %0d", lat, (ET ? 3 : 32));
    end
    do_op(1'b0, 32'd3, 32'h8000_0000, res, lat, be0, bf, fa);
    checks++;
    if (res !== 64'h1_8000_0000) begin
      errors++; $display("FAIL et_bmsb_result: got %0h expected 180000000", res);
    end
    checks++;
    if (lat !== 32) begin
      errors++; $display("FAIL et_bmsb_latency: got %0d expected 32", lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_reset_mid_run();
    test_width16_step4();
    test_early_term();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
